// File: rtl/instruction_fetch.sv
// Generic synchronous FIFO with a single-cycle flush that discards all entries.
// Latency: a pushed word is visible at head_dat one cycle after the push.
// Backpressure: none internal; the caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array: written on push, no reset needed since count guards the head.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping; flush behaves like a reset of the queue.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Fetch stage: holds the PC, requests instruction words, buffers them in order for decode.
// Latency: request accepted in cycle N, response in N+1, instruction valid to decode in N+2.
// Backpressure: FIFO slots are reserved at request time; requests stop while buffer+in-flight is full.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc;
  logic         reset_state;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW:0]   occupancy;
  logic [31:0]   resp_pc;
  logic          req_fire;
  logic          resp_drop;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // The word leaving to decode this cycle frees its slot now, so a 2-deep buffer streams at full rate.
  assign fifo_pop       = instr_valid && instr_ready;
  assign occupancy      = {1'b0, count} + {1'b0, inflight} - {{CW{1'b0}}, fifo_pop};
  assign imem_req_valid = !reset_state && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop  = (drop != '0);
  assign fifo_push  = imem_resp_valid && !resp_drop && !redirect_valid;
  assign push_entry = '{word: imem_resp_data, pc: resp_pc};

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? head_entry.word : 32'h0;
  assign instr_pc    = instr_valid ? head_entry.pc   : 32'h0;

  // Addresses of outstanding requests, in order; its occupancy is the in-flight count.
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_q (
    .clock    (clock),
    .reset    (reset),
    .flush    (1'b0),
    .push     (req_fire),
    .push_dat (pc),
    .pop      (imem_resp_valid),
    .head_dat (resp_pc),
    .count    (inflight)
  );

  // Prefetch buffer toward decode; a redirect discards everything buffered.
  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_prefetch (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .head_dat (head_entry),
    .count    (count)
  );

  // PC sequencing, post-reset request hold-off, and counting of stale responses to discard.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      reset_state <= 1'b1;
      drop        <= '0;
    end else begin
      reset_state <= 1'b0;
      if (redirect_valid) begin
        pc   <= redirect_pc & ~32'h3;
        drop <= inflight - CW'(imem_resp_valid);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_resp_valid && resp_drop) drop <= drop - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] req_exp;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          tests = 0;
  int          fails = 0;
  int          pop_cnt = 0;
  int          acc_cnt = 0;
  bit          prev_rst = 1'b0;
  bit          prev_redir = 1'b0;

  // Memory contents: a fixed scramble of the address, never zero for small addresses.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: after reset or redirect the fetch and delivery streams restart at p, p+4, ...
  task automatic restart(input logic [31:0] p);
    exp_q.delete();
    exp_next = p;
    req_exp  = p;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    if (reset) restart(RESET_PC);
    else if (redirect_valid) restart(redirect_pc & ~32'h3);
    while (exp_q.size() < 8) begin
      e.pc   = exp_next;
      e.word = memf(exp_next);
      exp_q.push_back(e);
      exp_next = exp_next + 32'd4;
    end
    #1;
  endtask

  // Instruction memory: records accepts, answers in order after a random latency, one per cycle.
  initial begin
    int d;
    logic [31:0] a;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        d = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(d);
      end
      @(posedge clock);
      cyc++;
      #2;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        a = pend_addr.pop_front();
        d = pend_due.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = memf(a);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  // Monitor: checks reset outputs, request addresses, flush behaviour and every word handed to decode.
  always @(negedge clock) begin
    exp_t e;
    if (prev_rst) begin
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
    end
    if (!reset) begin
      if (prev_redir) check("flush_instr_valid", {31'h0, instr_valid}, 32'h0);
      if (redirect_valid) check("no_req_in_redirect", {31'h0, imem_req_valid}, 32'h0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, req_exp);
        req_exp = req_exp + 32'd4;
        acc_cnt++;
      end
      if (instr_valid && instr_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("exp_available", 32'h0, 32'h1);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instruction", instruction, e.word);
        end
      end
    end
    prev_rst   = reset;
    prev_redir = redirect_valid && !reset;
  end

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int first;
    int p0;
    int a0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // 1: streaming from reset with a 1-cycle memory
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (instr_valid && first < 0) first = k;
      step();
    end
    check("first_instr_cycle", first, 3);
    p0 = pop_cnt;
    repeat (16) step();
    check("sustained_rate", pop_cnt - p0, 16);

    // 2: decode stalled -> exactly DEPTH requests, then resume in order
    instr_ready = 1'b0;
    do_reset();
    a0 = acc_cnt;
    repeat (12) step();
    check("accepts_while_stalled", acc_cnt - a0, DEPTH);
    @(negedge clock);
    check("req_valid_when_full", {31'h0, imem_req_valid}, 32'h0);
    step();
    instr_ready = 1'b1;
    repeat (10) step();

    // 3: redirect with responses in flight, unaligned target
    lat_min = 2;
    lat_max = 2;
    repeat (10) step();
    redirect(32'h0000_0103);
    repeat (20) step();

    // 4: redirect coinciding with a response and a pop
    lat_min = 0;
    lat_max = 0;
    repeat (12) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    @(negedge clock);
    check("redir_overlap", {29'h0, instr_valid, instr_ready, imem_resp_valid}, 32'h7);
    step();
    redirect_valid = 1'b0;
    repeat (12) step();

    // 5: address wrap
    redirect(32'hFFFF_FFF8);
    repeat (12) step();

    // 6: reset with the buffer full
    instr_ready = 1'b0;
    repeat (6) step();
    @(negedge clock);
    check("full_before_reset", {31'h0, instr_valid}, 32'h1);
    check("full_no_req", {31'h0, imem_req_valid}, 32'h0);
    step();
    do_reset();
    instr_ready = 1'b1;
    repeat (15) step();

    // Random traffic: stalls on both sides, variable latency, redirects and occasional resets
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      instr_ready    = ($urandom_range(3, 0) != 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom;
      reset          = ($urandom_range(299, 0) == 0);
      step();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    repeat (20) step();
    check("pop_total_min", {31'h0, pop_cnt > 200}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
